// File: rtl/cla_word_sequencer.sv
// Drives one shared 4-bit CLA slice a nibble at a time to build a NIBBLES*4-bit add/subtract.
// The carry is chained through a register between nibbles; operands and result move on valid/ready.
module cla_word_sequencer #(
    parameter int NIBBLES = 4,
    parameter int ADD_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    input  logic                   op_sub,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_ci,
    input  logic [3:0]             slice_s,
    input  logic                   slice_co,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_ovf,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_cap;
    logic               w_last;
    logic [IDX_W+1:0]   w_bit;

    assign w_accept = (r_state == S_IDLE) && start_valid;
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_bit    = {r_idx, 2'b00};
    // With a registered slice the result is only valid in WAIT, one clock after issue.
    assign w_cap    = ((r_state == S_ISSUE) && (ADD_LAT == 0)) || (r_state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_next = S_ISSUE;
            S_ISSUE: begin
                if (ADD_LAT != 0) w_next = S_WAIT;
                else if (w_last)  w_next = S_DONE;
                else              w_next = S_ISSUE;
            end
            S_WAIT:  w_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        res_valid   = (r_state == S_DONE);
        slice_a     = 4'd0;
        slice_b     = 4'd0;
        slice_ci    = 1'b0;
        if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
            slice_a  = r_a[w_bit +: 4];
            slice_b  = r_b[w_bit +: 4];
            slice_ci = r_carry;
        end
    end

    // Partial sums build in r_acc so the published result only changes on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= op_sub ? 1'b1 : op_cin;
            r_a     <= op_a;
            r_b     <= op_sub ? ~op_b : op_b;
            r_acc   <= '0;
        end else if (w_cap) begin
            r_acc[w_bit +: 4] <= slice_s;
            r_carry           <= slice_co;
            if (w_last) begin
                r_sum  <= {slice_s, r_acc[W-5:0]};
                r_cout <= slice_co;
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (slice_s[3] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign res_sum  = r_sum;
    assign res_cout = r_cout;
    assign res_ovf  = r_ovf;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Two sequencers: index 0 with a combinational slice, index 1 with a registered slice.
module tb_cla_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] op_a, op_b;
    logic        op_cin, op_sub, res_ready;
    logic        sv   [2];
    logic        sr   [2];
    logic [3:0]  sa   [2];
    logic [3:0]  sb   [2];
    logic        sci  [2];
    logic [3:0]  ss   [2];
    logic        sco  [2];
    logic        rv   [2];
    logic [15:0] rsum [2];
    logic        rco  [2];
    logic        rov  [2];
    logic        bsy  [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_word_sequencer #(.NIBBLES(4), .ADD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .slice_a(sa[0]), .slice_b(sb[0]), .slice_ci(sci[0]),
        .slice_s(ss[0]), .slice_co(sco[0]),
        .res_valid(rv[0]), .res_ready(res_ready), .res_sum(rsum[0]),
        .res_cout(rco[0]), .res_ovf(rov[0]), .busy(bsy[0]));

    cla_word_sequencer #(.NIBBLES(4), .ADD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .slice_a(sa[1]), .slice_b(sb[1]), .slice_ci(sci[1]),
        .slice_s(ss[1]), .slice_co(sco[1]),
        .res_valid(rv[1]), .res_ready(res_ready), .res_sum(rsum[1]),
        .res_cout(rco[1]), .res_ovf(rov[1]), .busy(bsy[1]));

    // Slice models: plain 4-bit adders, the second one registered.
    always_comb {sco[0], ss[0]} = 5'(sa[0]) + 5'(sb[0]) + 5'(sci[0]);
    always_ff @(posedge clk) {sco[1], ss[1]} <= 5'(sa[1]) + 5'(sb[1]) + 5'(sci[1]);

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub, input int hold);
        int unsigned beff, c0, full, lo, cin_n;
        int          sa_i, sb_i, r, n, idx, lat;
        logic [15:0] e_sum;
        logic        e_co, e_ov;
        logic [3:0]  pa, pb;
        logic        pc;
        beff  = sub ? (~int'(b) & 32'hFFFF) : int'(b);
        c0    = sub ? 1 : int'(ci);
        full  = int'(a) + beff + c0;
        e_sum = full[15:0];
        e_co  = full[16];
        sa_i  = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb_i  = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        r     = sub ? sa_i - sb_i : sa_i + sb_i + int'(ci);
        e_ov  = (r > 32767) || (r < -32768);
        lat   = d ? 9 : 5;
        pa = 0; pb = 0; pc = 0;

        @(negedge clk);
        op_a = a; op_b = b; op_cin = ci; op_sub = sub; sv[d] = 1'b1;
        n_chk++;
        if (sr[d] !== 1'b1) begin n_fail++; $display("FAIL start_ready_idle d=%0d got=%b exp=1", d, sr[d]); end
        @(negedge clk);
        sv[d] = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom); op_sub = 1'($urandom);
        n = 1;
        while (rv[d] !== 1'b1 && n < 40) begin
            idx   = (n - 1) / (d + 1);
            lo    = (32'd1 << (4 * idx)) - 1;
            cin_n = ((int'(a) & lo) + (beff & lo) + c0) >> (4 * idx);
            if (idx < 4) begin
                n_chk++;
                if (sa[d] !== a[4*idx +: 4] || sb[d] !== 4'(beff >> (4*idx)) || sci[d] !== cin_n[0] || bsy[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL slice_drive d=%0d n=%0d got a=%h b=%h ci=%b busy=%b exp a=%h b=%h ci=%b busy=1",
                             d, n, sa[d], sb[d], sci[d], bsy[d], a[4*idx +: 4], 4'(beff >> (4*idx)), cin_n[0]);
                end
            end
            if (d == 1 && (n % 2) == 0) begin
                n_chk++;
                if (sa[d] !== pa || sb[d] !== pb || sci[d] !== pc) begin
                    n_fail++;
                    $display("FAIL slice_hold_wait n=%0d got %h/%h/%b exp %h/%h/%b", n, sa[d], sb[d], sci[d], pa, pb, pc);
                end
            end
            pa = sa[d]; pb = sb[d]; pc = sci[d];
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n !== lat) begin n_fail++; $display("FAIL latency d=%0d got=%0d exp=%0d", d, n, lat); end
        n_chk++;
        if (rsum[d] !== e_sum || rco[d] !== e_co || rov[d] !== e_ov) begin
            n_fail++;
            $display("FAIL result d=%0d a=%h b=%h ci=%b sub=%b got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b",
                     d, a, b, ci, sub, rsum[d], rco[d], rov[d], e_sum, e_co, e_ov);
        end
        n_chk++;
        if (sa[d] !== 4'd0 || sb[d] !== 4'd0 || sci[d] !== 1'b0 || sr[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_outputs d=%0d got sa=%h sb=%h ci=%b sr=%b exp 0/0/0/0", d, sa[d], sb[d], sci[d], sr[d]);
        end
        for (int k = 0; k < hold; k++) begin
            sv[d] = 1'($urandom);
            op_a = 16'($urandom); op_b = 16'($urandom);
            @(negedge clk);
            n_chk++;
            if (rv[d] !== 1'b1 || sr[d] !== 1'b0 || rsum[d] !== e_sum || rco[d] !== e_co || rov[d] !== e_ov) begin
                n_fail++;
                $display("FAIL done_hold d=%0d k=%0d got rv=%b sr=%b sum=%h exp rv=1 sr=0 sum=%h", d, k, rv[d], sr[d], rsum[d], e_sum);
            end
        end
        sv[d] = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_chk++;
        if (rv[d] !== 1'b0 || sr[d] !== 1'b1 || bsy[d] !== 1'b0 || rsum[d] !== e_sum || rco[d] !== e_co) begin
            n_fail++;
            $display("FAIL release d=%0d got rv=%b sr=%b busy=%b sum=%h exp rv=0 sr=1 busy=0 sum=%h", d, rv[d], sr[d], bsy[d], rsum[d], e_sum);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sr[d] !== 1'b1 || rv[d] !== 1'b0 || bsy[d] !== 1'b0 || sa[d] !== 4'd0 || sb[d] !== 4'd0 ||
                sci[d] !== 1'b0 || rsum[d] !== 16'd0 || rco[d] !== 1'b0 || rov[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state d=%0d got sr=%b rv=%b busy=%b sa=%h sum=%h co=%b ov=%b exp sr=1 rest 0",
                         d, sr[d], rv[d], bsy[d], sa[d], rsum[d], rco[d], rov[d]);
            end
        end
    endtask

    task automatic test_directed();
        run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_op(0, 16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 10);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h0FFF; op_cin = 1'b0; op_sub = 1'b0; sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sa[0] !== 4'h2 || bsy[0] !== 1'b1) begin
            n_fail++; $display("FAIL midop_idx2 got sa=%h busy=%b exp sa=2 busy=1", sa[0], bsy[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (sr[0] !== 1'b1 || rv[0] !== 1'b0 || bsy[0] !== 1'b0 || sa[0] !== 4'd0 || sb[0] !== 4'd0 ||
            sci[0] !== 1'b0 || rsum[0] !== 16'd0 || rco[0] !== 1'b0 || rov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got sr=%b rv=%b busy=%b sa=%h sum=%h co=%b exp sr=1 rest 0",
                     sr[0], rv[0], bsy[0], sa[0], rsum[0], rco[0]);
        end
        #1 rst = 1'b0;
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    endtask

    task automatic test_registered_slice();
        run_op(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        run_op(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(i % 2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b0; sv[0] = 1'b0; sv[1] = 1'b0;
        op_a = 16'd0; op_b = 16'd0; op_cin = 1'b0; op_sub = 1'b0;
        #3;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_registered_slice();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
